// File: rtl/pattern_sequencer_pkg.sv
// pattern_sequencer_pkg: debounce state encoding and shared counter helpers
package pattern_sequencer_pkg;
  typedef enum logic [2:0] {
    DB_IDLE    = 3'd0,
    DB_PRESS   = 3'd1,
    DB_HELD    = 3'd2,
    DB_WAIT_UP = 3'd3,
    DB_RELEASE = 3'd4
  } db_state_e;
  localparam int CNT_W = 28;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/pattern_sequencer_debounce.sv
// pattern_sequencer_debounce: synchronises the raw key and emits one short or long pulse per press
module pattern_sequencer_debounce
  import pattern_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 150000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic short_pulse_o,
  output logic long_pulse_o
);
  localparam logic [CNT_W-1:0] DB_END = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_END = CNT_W'(LONG_PRESS_CYCLES - 1);
  logic [1:0] sync_q;
  db_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic key_hi;
  assign key_hi = sync_q[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // cnt keeps running from PRESS into HELD, so in HELD it measures the whole press length
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    short_pulse_o = 1'b0;
    long_pulse_o  = 1'b0;
    case (state_q)
      DB_IDLE: if (!key_hi) begin
        state_d = DB_PRESS;
        cnt_d   = '0;
      end
      DB_PRESS: begin
        cnt_d   = sat_inc(cnt_q);
        state_d = key_hi ? DB_IDLE : (cnt_q == DB_END ? DB_HELD : DB_PRESS);
      end
      DB_HELD: if (key_hi) begin
        state_d       = DB_RELEASE;
        cnt_d         = '0;
        short_pulse_o = 1'b1;
      end else if (cnt_q >= LP_END) begin
        state_d      = DB_WAIT_UP;
        long_pulse_o = 1'b1;
      end else begin
        cnt_d = sat_inc(cnt_q);
      end
      DB_WAIT_UP: if (key_hi) begin
        state_d = DB_RELEASE;
        cnt_d   = '0;
      end
      DB_RELEASE: begin
        cnt_d   = !key_hi ? '0 : sat_inc(cnt_q);
        state_d = (key_hi && cnt_q == DB_END) ? DB_IDLE : DB_RELEASE;
      end
      default: state_d = DB_IDLE;
    endcase
  end
endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: picks one of NUM_PATTERNS video sources, stepping only on frame boundaries
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int NUM_PATTERNS      = 8,
  parameter int SEL_W             = 3,
  parameter int FRAMES_PER_PAT    = 120,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 150000000,
  parameter bit VS_POL            = 1'b1,
  parameter bit AUTO_DEFAULT      = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      key_n,
  input  logic [NUM_PATTERNS-1:0]   pat_hs,
  input  logic [NUM_PATTERNS-1:0]   pat_vs,
  input  logic [NUM_PATTERNS-1:0]   pat_de,
  input  logic [24*NUM_PATTERNS-1:0] pat_rgb,
  output logic                      hs,
  output logic                      vs,
  output logic                      de,
  output logic [7:0]                rgb_r,
  output logic [7:0]                rgb_g,
  output logic [7:0]                rgb_b,
  output logic [SEL_W-1:0]          pattern_sel,
  output logic                      auto_mode
);
  localparam logic [15:0] LAST_FRAME = 16'(FRAMES_PER_PAT - 1);
  localparam logic [SEL_W-1:0] LAST_PAT = SEL_W'(NUM_PATTERNS - 1);
  logic short_pulse, long_pulse;
  logic vs_act_q, fb, adv;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic step_pend_q, step_pend_d, auto_q, auto_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [26:0] out_q, out_d;
  pattern_sequencer_debounce #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
  ) u_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_n_i      (key_n),
    .short_pulse_o(short_pulse),
    .long_pulse_o (long_pulse)
  );
  // vs_act_q resets as "already in vsync" so releasing reset inside vsync cannot fake a boundary
  assign fb  = (pat_vs[0] == VS_POL) && !vs_act_q;
  assign adv = step_pend_q | (auto_q & (frame_cnt_q == LAST_FRAME));
  always_comb begin
    sel_d       = (fb && adv) ? (sel_q == LAST_PAT ? '0 : sel_q + 1'b1) : sel_q;
    frame_cnt_d = (long_pulse || (fb && adv) || !auto_q) ? '0 :
                  fb ? frame_cnt_q + 16'd1 : frame_cnt_q;
    step_pend_d = short_pulse | (step_pend_q & !long_pulse & !(fb && adv));
    auto_d      = auto_q ^ long_pulse;
    out_d       = '0;
    for (int i = 0; i < NUM_PATTERNS; i++)
      if (sel_q == SEL_W'(i)) out_d = {pat_hs[i], pat_vs[i], pat_de[i], pat_rgb[24*i +: 24]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_act_q    <= 1'b1;
      frame_cnt_q <= '0;
      step_pend_q <= 1'b0;
      auto_q      <= AUTO_DEFAULT;
      sel_q       <= '0;
      out_q       <= '0;
    end else begin
      vs_act_q    <= pat_vs[0] == VS_POL;
      frame_cnt_q <= frame_cnt_d;
      step_pend_q <= step_pend_d;
      auto_q      <= auto_d;
      sel_q       <= sel_d;
      out_q       <= out_d;
    end
  end
  assign {hs, vs, de, rgb_r, rgb_g, rgb_b} = out_q;
  assign pattern_sel = sel_q;
  assign auto_mode   = auto_q;
endmodule
